// File: rtl/plot_arbiter_if.sv
// Bundle between the drawing clients and plot_arbiter, plus the arbiter's VGA plot outputs.
// req is a level: a client raises it with its command fields stable and holds both until it
// sees its one-cycle ack; done pulses once when that rectangle has been fully rasterised.
// The pixel port (x, y, colour, writeEn) has no backpressure: writeEn marks a valid pixel.
interface plot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COL_W   = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*X_W-1:0]   req_x;
  logic [NUM_REQ*Y_W-1:0]   req_y;
  logic [NUM_REQ*X_W-1:0]   req_w;
  logic [NUM_REQ*Y_W-1:0]   req_h;
  logic [NUM_REQ*COL_W-1:0] req_colour;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       done;
  logic [X_W-1:0]           x;
  logic [Y_W-1:0]           y;
  logic [COL_W-1:0]         colour;
  logic                     writeEn;
  logic                     busy;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  ack, done, x, y, colour, writeEn, busy
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output ack, done, x, y, colour, writeEn, busy
  );
endinterface

// File: rtl/plot_arbiter.sv
// Grants drawing clients one filled rectangle at a time and rasterises it row-major, one pixel
// per clock, clipped to the screen. Define PLOT_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module plot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              reset,
  plot_arbiter_if.slave     bus,
  output logic [1:0]        o_dbg_state
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [X_W-1:0]     r_x0, r_w, r_dx;
  logic [Y_W-1:0]     r_y0, r_h, r_dy;
  logic [COL_W-1:0]   r_col;
  logic [GW-1:0]      r_grant;

  logic [NUM_REQ-1:0] r_ack, r_done;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COL_W-1:0]   r_colour;
  logic               r_we, r_busy;

  logic               w_grant_valid;
  logic [GW-1:0]      w_grant;
  logic [GW-1:0]      w_idx;

`ifdef PLOT_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = GW'(i);
      if (bus.req[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_idx;
      end
    end
  end
`else
  logic [GW-1:0] r_rr;

  // Search starts just above the last grant, so a holder is never passed over twice.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = GW'((int'(r_rr) + i) % NUM_REQ);
      if (!w_grant_valid && bus.req[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= GW'(NUM_REQ - 1);
    end else if (r_state == S_IDLE && w_grant_valid) begin
      r_rr <= w_grant;
    end
  end
`endif

  logic [X_W-1:0]   w_sel_x, w_sel_w;
  logic [Y_W-1:0]   w_sel_y, w_sel_h;
  logic [COL_W-1:0] w_sel_col;

  assign w_sel_x   = bus.req_x[int'(w_grant) * X_W +: X_W];
  assign w_sel_w   = bus.req_w[int'(w_grant) * X_W +: X_W];
  assign w_sel_y   = bus.req_y[int'(w_grant) * Y_W +: Y_W];
  assign w_sel_h   = bus.req_h[int'(w_grant) * Y_W +: Y_W];
  assign w_sel_col = bus.req_colour[int'(w_grant) * COL_W +: COL_W];

  // One extra bit keeps origins near the right/bottom edge from wrapping back on-screen.
  logic [X_W:0] w_sum_x;
  logic [Y_W:0] w_sum_y;
  logic         w_in_bounds, w_last_col, w_last_row;

  assign w_sum_x     = {1'b0, r_x0} + {1'b0, r_dx};
  assign w_sum_y     = {1'b0, r_y0} + {1'b0, r_dy};
  assign w_in_bounds = (w_sum_x < (X_W+1)'(SCREEN_W)) && (w_sum_y < (Y_W+1)'(SCREEN_H));
  assign w_last_col  = (r_dx == r_w - X_W'(1));
  assign w_last_row  = (r_dy == r_h - Y_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          if (w_sel_w == '0 || w_sel_h == '0) w_next_state = S_FINISH;
          else                                w_next_state = S_DRAW;
        end
      end
      S_DRAW:   if (w_last_col && w_last_row) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  logic [NUM_REQ-1:0] w_ack_n, w_done_n;
  logic [X_W-1:0]     w_x_n;
  logic [Y_W-1:0]     w_y_n;
  logic [COL_W-1:0]   w_col_n;
  logic               w_we_n;

  // Pixel outputs hold their previous value on any cycle without a write.
  always_comb begin
    w_ack_n  = '0;
    w_done_n = '0;
    w_we_n   = 1'b0;
    w_x_n    = r_x;
    w_y_n    = r_y;
    w_col_n  = r_colour;
    case (r_state)
      S_IDLE: if (w_grant_valid) w_ack_n[w_grant] = 1'b1;
      S_DRAW: begin
        if (w_in_bounds) begin
          w_we_n  = 1'b1;
          w_x_n   = w_sum_x[X_W-1:0];
          w_y_n   = w_sum_y[Y_W-1:0];
          w_col_n = r_col;
        end
      end
      S_FINISH: w_done_n[r_grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack    <= '0;
      r_done   <= '0;
      r_we     <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_busy   <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_grant  <= '0;
    end else begin
      r_ack    <= w_ack_n;
      r_done   <= w_done_n;
      r_we     <= w_we_n;
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_colour <= w_col_n;
      r_busy   <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_x0    <= w_sel_x;
            r_y0    <= w_sel_y;
            r_w     <= w_sel_w;
            r_h     <= w_sel_h;
            r_col   <= w_sel_col;
            r_grant <= w_grant;
            r_dx    <= '0;
            r_dy    <= '0;
          end
        end
        S_DRAW: begin
          if (w_last_col) begin
            r_dx <= '0;
            r_dy <= r_dy + Y_W'(1);
          end else begin
            r_dx <= r_dx + X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.done    = r_done;
  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.colour  = r_colour;
  assign bus.writeEn = r_we;
  assign bus.busy    = r_busy;
  assign o_dbg_state = r_state;
endmodule
